// File: rtl/matrix_cfg_loader.sv
// Shadow-buffered loader for the 18 routing descriptors of a 5x4 switch-matrix tile.
// Optional readback port of the committed configuration: define MATRIX_CFG_READBACK_EN.
module matrix_cfg_loader #(
  parameter int N_TB = 5,
  parameter int N_LR = 4,
  parameter int DW   = 6
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               cfg_valid,
  input  logic [DW-1:0]                      cfg_data,
  output logic                               cfg_ready,
  output logic                               busy,
  output logic                               done,
  output logic                               err,
  output logic [1:0]                         err_code,
  output logic [(2*N_TB+2*N_LR)*DW-1:0]      active_cfg,
  output logic [7:0]                         commit_cnt
`ifdef MATRIX_CFG_READBACK_EN
  ,
  input  logic                               rd_en,
  input  logic [4:0]                         rd_addr,
  output logic [DW-1:0]                      rd_data,
  output logic                               rd_valid
`endif
);

  localparam int N_ENT = 2*N_TB + 2*N_LR;
  localparam int KW    = $clog2(N_ENT);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_CSUM   = 3'd2;
  localparam logic [2:0] S_COMMIT = 3'd3;
  localparam logic [2:0] S_ERR    = 3'd4;

  localparam logic [1:0] E_NONE = 2'd0;
  localparam logic [1:0] E_SIDE = 2'd1;
  localparam logic [1:0] E_IDX  = 2'd2;
  localparam logic [1:0] E_CSUM = 2'd3;

  logic [2:0]            state;
  logic [KW-1:0]         cnt;
  logic [DW-1:0]         xsum;
  logic [N_ENT*DW-1:0]   shadow;
  logic [DW-1:0]         csum_word_p0;
  logic                  vld_p0;
  logic                  xfer;
  logic [1:0]            chk;

  // Source side encoding: 0 off, 1 top, 2 right, 3 bottom, 4 left.
  // Destination side of entry k follows the top/bottom/left/right ordering.
  function automatic logic [1:0] desc_check(input logic [DW-1:0] w, input logic [KW-1:0] k);
    int side;
    int idx;
    int kk;
    int dside;
    int didx;
    side = int'(w[2:0]);
    idx  = int'(w[DW-1:3]);
    kk   = int'(k);
    if (kk < N_TB) begin
      dside = 1;
      didx  = kk;
    end else if (kk < 2*N_TB) begin
      dside = 3;
      didx  = kk - N_TB;
    end else if (kk < 2*N_TB + N_LR) begin
      dside = 4;
      didx  = kk - 2*N_TB;
    end else begin
      dside = 2;
      didx  = kk - 2*N_TB - N_LR;
    end
    desc_check = E_NONE;
    if (side == 0)
      desc_check = E_NONE;
    else if (side > 4)
      desc_check = E_SIDE;
    else if ((side == 1 || side == 3) && idx >= N_TB)
      desc_check = E_IDX;
    else if ((side == 2 || side == 4) && idx >= N_LR)
      desc_check = E_IDX;
    else if (side == dside && idx == didx)
      desc_check = E_IDX;
  endfunction

  // The checksum word is registered before comparison, so CSUM stops
  // accepting while the captured word is pending.
  assign cfg_ready = (state == S_LOAD) || (state == S_CSUM && !vld_p0);
  assign busy      = (state == S_LOAD) || (state == S_CSUM);
  assign xfer      = cfg_valid && cfg_ready;
  assign chk       = desc_check(cfg_data, cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      xsum         <= '0;
      shadow       <= '0;
      csum_word_p0 <= '0;
      vld_p0       <= 1'b0;
      active_cfg   <= '0;
      commit_cnt   <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_code     <= E_NONE;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_ERR: begin
          if (start) begin
            state    <= S_LOAD;
            cnt      <= '0;
            xsum     <= '0;
            vld_p0   <= 1'b0;
            err      <= 1'b0;
            err_code <= E_NONE;
          end
        end
        S_LOAD: begin
          if (start) begin
            cnt  <= '0;
            xsum <= '0;
          end else if (xfer) begin
            if (chk != E_NONE) begin
              err      <= 1'b1;
              err_code <= chk;
              state    <= S_ERR;
            end else begin
              shadow[int'(cnt)*DW +: DW] <= cfg_data;
              xsum <= xsum ^ cfg_data;
              if (cnt == KW'(N_ENT-1))
                state <= S_CSUM;
              else
                cnt <= cnt + 1'b1;
            end
          end
        end
        // Stage p0: captured checksum word compared against the running XOR
        S_CSUM: begin
          if (start) begin
            state  <= S_LOAD;
            cnt    <= '0;
            xsum   <= '0;
            vld_p0 <= 1'b0;
          end else if (vld_p0) begin
            vld_p0 <= 1'b0;
            if (csum_word_p0 == xsum) begin
              state <= S_COMMIT;
            end else begin
              err      <= 1'b1;
              err_code <= E_CSUM;
              state    <= S_ERR;
            end
          end else if (xfer) begin
            csum_word_p0 <= cfg_data;
            vld_p0       <= 1'b1;
          end
        end
        S_COMMIT: begin
          active_cfg <= shadow;
          commit_cnt <= commit_cnt + 8'd1;
          done       <= 1'b1;
          if (start) begin
            state    <= S_LOAD;
            cnt      <= '0;
            xsum     <= '0;
            err      <= 1'b0;
            err_code <= E_NONE;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MATRIX_CFG_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        if (int'(rd_addr) < N_ENT)
          rd_data <= active_cfg[int'(rd_addr)*DW +: DW];
        else
          rd_data <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_matrix_cfg_loader.sv
// Directed bench for matrix_cfg_loader: good frames, descriptor errors, checksum, restart, reset.
module tb_matrix_cfg_loader;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         cfg_valid;
  logic [5:0]   cfg_data;
  logic         cfg_ready;
  logic         busy;
  logic         done;
  logic         err;
  logic [1:0]   err_code;
  logic [107:0] active_cfg;
  logic [7:0]   commit_cnt;

  int checks = 0;
  int errors = 0;

  logic [5:0]   frame [18];
  logic [107:0] exp_act;

  matrix_cfg_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_valid  (cfg_valid),
    .cfg_data   (cfg_data),
    .cfg_ready  (cfg_ready),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .active_cfg (active_cfg),
    .commit_cnt (commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [5:0] w);
    cfg_valid = 1'b1;
    cfg_data  = w;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic send_frame(input int n);
    for (int i = 0; i < n; i++) send(frame[i]);
  endtask

  // Frame G: right source index 1 everywhere, except right[1] itself (k=15) disconnected.
  task automatic set_g();
    for (int i = 0; i < 18; i++) frame[i] = (i == 15) ? 6'b000_000 : 6'b001_010;
  endtask

  // Frame B: top source index 3 everywhere, except top[3] (k=3) takes bottom[4].
  task automatic set_b();
    for (int i = 0; i < 18; i++) frame[i] = (i == 3) ? 6'b100_011 : 6'b011_001;
  endtask

  function automatic logic [107:0] pack_frame();
    logic [107:0] p;
    p = '0;
    for (int i = 0; i < 18; i++) p[i*6 +: 6] = frame[i];
    return p;
  endfunction

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    tick();
    tick();
    chk("rst_active", active_cfg, 0);
    chk("rst_ready", cfg_ready, 0);
    chk("rst_cnt", commit_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", {err, err_code}, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", cfg_ready, 0);

    // Good frame G; checksum of 17 copies of 001010 plus 0 is 001010
    set_g();
    pulse_start();
    chk("load_ready", cfg_ready, 1);
    chk("load_busy", busy, 1);
    send_frame(18);
    chk("csum_ready", cfg_ready, 1);
    send(6'b001_010);
    chk("csum_pend_ready", cfg_ready, 0);
    chk("g_done_n1", done, 0);
    tick();
    chk("g_done_n1b", done, 0);
    chk("g_active_n1", active_cfg, 0);
    tick();
    exp_act = pack_frame();
    chk("g_done_n2", done, 1);
    chk("g_active", active_cfg, exp_act);
    chk("g_cnt", commit_cnt, 1);
    tick();
    chk("g_done_pulse", done, 0);
    chk("g_idle_busy", busy, 0);

    // Bad side at k=3
    pulse_start();
    send(6'b001_010);
    send(6'b001_010);
    send(6'b001_010);
    send(6'b000_101);
    chk("side_err", err, 1);
    chk("side_code", err_code, 1);
    chk("side_ready", cfg_ready, 0);
    chk("side_busy", busy, 0);
    chk("side_active", active_cfg, exp_act);
    send(6'b001_010);
    chk("err_ignore_valid", {err, err_code}, 3'b101);

    // Bad index: right[5]
    pulse_start();
    chk("start_clr_err", {err, err_code}, 0);
    send(6'b101_010);
    chk("idx_code", {err, err_code}, 3'b110);
    // Self-loop: top0 selects top0
    pulse_start();
    send(6'b000_001);
    chk("loop_code", {err, err_code}, 3'b110);
    chk("loop_active", active_cfg, exp_act);

    // Checksum mismatch on frame B (correct XOR = 111010)
    set_b();
    pulse_start();
    send_frame(18);
    send(6'b111_011);
    tick();
    chk("csum_err", {err, err_code}, 3'b111);
    chk("csum_no_done", done, 0);
    tick();
    chk("csum_no_done2", done, 0);
    chk("csum_cnt", commit_cnt, 1);
    chk("csum_active", active_cfg, exp_act);

    pulse_start();
    chk("csum_clr", {err, err_code}, 0);
    send_frame(18);
    send(6'b111_010);
    tick();
    tick();
    exp_act = pack_frame();
    chk("b_done", done, 1);
    chk("b_active", active_cfg, exp_act);
    chk("b_cnt", commit_cnt, 2);
    chk("b_err", err, 0);

    // Restart after 7 transfers; the coincident (bad) word must be dropped
    set_g();
    pulse_start();
    send_frame(7);
    start     = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = 6'b000_101;
    tick();
    start     = 1'b0;
    cfg_valid = 1'b0;
    chk("rs_no_err", err, 0);
    chk("rs_busy", busy, 1);
    chk("rs_active", active_cfg, exp_act);
    send_frame(18);
    chk("rs_csum_ready", {busy, cfg_ready}, 2'b11);
    send(6'b001_010);
    tick();
    tick();
    exp_act = pack_frame();
    chk("rs_done", done, 1);
    chk("rs_active2", active_cfg, exp_act);
    chk("rs_cnt", commit_cnt, 3);

    // Reset mid-frame
    pulse_start();
    send_frame(5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_active", active_cfg, 0);
    chk("mid_rst_cnt", commit_cnt, 0);
    chk("mid_rst_ready", {cfg_ready, busy, done, err, err_code}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", cfg_ready, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
